// File: rtl/periph_7seg.sv
// Memory-mapped 8-digit hex display driver with tear-free shadow and anti-ghost scan.
// Optional: define PERIPH_7SEG_LZ_BLANK_EN for leading-zero blanking.
module periph_7seg #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 10000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [31:0]           data_q, data_d;
  logic [31:0]           disp_q, disp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            nib;
`ifdef PERIPH_7SEG_LZ_BLANK_EN
  logic [IW-1:0]         msd;
`endif

  always_comb begin
    data_d    = we_i ? data_i : data_q;
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // shadow only moves at the frame boundary, so a frame never tears
    disp_d    = frame_end ? data_q : disp_q;
    nib       = 4'(disp_q >> {idx_q, 2'b00});
    an_d      = (cnt_q == '0) ? '1 : ~(AN_ONE << idx_q);
`ifdef PERIPH_7SEG_LZ_BLANK_EN
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (disp_q[4*i +: 4] != 4'h0) msd = IW'(i);
    if (idx_q > msd) an_d = '1;
`endif
    seg_d = 7'h7F;
    unique case (nib)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
    end else begin
      data_q <= data_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign data_o = data_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;

endmodule

// File: tb/tb_periph_7seg.sv
// Directed bench for periph_7seg with DIGIT_CYCLES=4.
// Frame-by-frame checks of anodes, segments, readback and the shadow latch.
module tb_periph_7seg;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] data_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_data = '0;

  typedef struct {
    logic [31:0]     data;
    logic [7:0][6:0] segs;
  } vec_t;

  vec_t vt[8];
  logic [7:0][6:0] all_zero_segs;

  periph_7seg #(.NUM_DIGITS(8), .DIGIT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .data_i(wdata),
    .data_o(data_o), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] lit_mask(input logic [31:0] v);
    logic [7:0] m;
    m = 8'hFF;
`ifdef PERIPH_7SEG_LZ_BLANK_EN
    begin
      int top;
      top = 0;
      for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) top = i;
      for (int i = 0; i < 8; i++) m[i] = (i <= top);
    end
`endif
    return m;
  endfunction

  // Called at a negedge whose next posedge starts a frame (cnt=0, idx=0).
  task automatic run_frame(input string tag, input logic [31:0] shown,
                           input logic [7:0][6:0] segs,
                           input int wr_at, input logic [31:0] wr_val);
    logic [7:0] mask;
    logic [7:0] exp_an;
    int slot;
    int ph;
    mask = lit_mask(shown);
    for (int j = 0; j < 32; j++) begin
      if (j == wr_at) begin
        we = 1'b1;
        wdata = wr_val;
      end
      @(posedge clk);
      if (j == wr_at) exp_data = wr_val;
      @(negedge clk);
      we = 1'b0;
      slot = j / 4;
      ph = j % 4;
      exp_an = (ph == 0 || !mask[slot]) ? 8'hFF : ~(8'h01 << slot);
      chk($sformatf("%s an j%0d", tag, j), {24'h0, an_o}, {24'h0, exp_an});
      chk($sformatf("%s seg j%0d", tag, j), {25'h0, seg_o},
          {25'h0, segs[slot]});
      chk($sformatf("%s data j%0d", tag, j), data_o, exp_data);
      chk($sformatf("%s dp j%0d", tag, j), {31'h0, dp_o}, 32'h1);
    end
  endtask

  initial begin
    all_zero_segs = {8{7'h40}};
    vt[0].data = 32'h89ABCDEF;
    vt[0].segs = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[1].data = 32'h12345678;
    vt[1].segs = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vt[2].data = 32'h0F0F1234;
    vt[2].segs = {7'h40, 7'h0E, 7'h40, 7'h0E, 7'h79, 7'h24, 7'h30, 7'h19};
    vt[3].data = 32'h00000000;
    vt[3].segs = {8{7'h40}};
    vt[4].data = 32'h76543210;
    vt[4].segs = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    vt[5].data = 32'hFEDCBA98;
    vt[5].segs = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    vt[6].data = 32'h00000A05;
    vt[6].segs = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12};
    vt[7].data = 32'h00000000;
    vt[7].segs = {8{7'h40}};

    rst_n = 1'b0;
    we    = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset an", {24'h0, an_o}, 32'hFF);
    chk("reset seg", {25'h0, seg_o}, 32'h7F);
    chk("reset data", data_o, 32'h0);
    chk("reset dp", {31'h0, dp_o}, 32'h1);
    rst_n = 1'b1;

    // Frame k shows the vector written during frame k-1.
    for (int k = 0; k < 9; k++) begin
      if (k == 0)
        run_frame("tbl0", 32'h0, all_zero_segs, 10, vt[0].data);
      else if (k < 8)
        run_frame($sformatf("tbl%0d", k), vt[k-1].data, vt[k-1].segs,
                  (k * 7) % 31, vt[k].data);
      else
        run_frame("tbl8", vt[7].data, vt[7].segs, -1, 32'h0);
    end

    // Write on the frame-wrap edge: shadow keeps the old value one more frame.
    run_frame("wrapA", 32'h0, all_zero_segs, 31, vt[1].data);
    run_frame("wrapB", 32'h0, all_zero_segs, -1, 32'h0);
    run_frame("wrapC", vt[1].data, vt[1].segs, -1, 32'h0);

    // Asynchronous reset in the middle of a lit slot.
    repeat (6) @(negedge clk);
    chk("pre-rst an", {24'h0, an_o}, 32'hFD);
    #20;
    rst_n = 1'b0;
    #1;
    chk("mid-rst an", {24'h0, an_o}, 32'hFF);
    chk("mid-rst seg", {25'h0, seg_o}, 32'h7F);
    chk("mid-rst data", data_o, 32'h0);
    exp_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("postrst", 32'h0, all_zero_segs, -1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
